tx_link_seq: RTL and testbench

Transmit-side link-layer sequencer for the JESD204B lane. Runs the full TX link bring-up (code group synchronization, LMFC-aligned initial lane alignment, user data) from the receiver's SYNC~ and the local frame/LMFC pulses. Drives the octet-stream select that feeds the 8b/10b encoder mux. Also classifies SYNC~ activity in data phase as re-synchronization requests or error reports.

---
 rtl/jesd_tx_pkg.sv | 26 ++
 rtl/tx_link_seq_sync_n_monitor.sv | 51 +++++
 rtl/tx_link_seq.sv | 124 ++++++++++++
 tb/tb_tx_link_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_tx_pkg.sv
// Shared JESD204B transmit definitions: link sequencer states and encoder mux codes.
// Used by tx_link_seq, the encoder mux and the ILA generator.
package jesd_tx_pkg;

    typedef enum logic [4:0] {
        ST_DISABLED  = 5'b00001,
        ST_CGS       = 5'b00010,
        ST_WAIT_LMFC = 5'b00100,
        ST_ILA       = 5'b01000,
        ST_DATA      = 5'b10000
    } link_state_e;

    localparam logic [2:0] LINK_MUX_USER = 3'd0;
    localparam logic [2:0] LINK_MUX_K    = 3'd1;
    localparam logic [2:0] LINK_MUX_ILA  = 3'd2;

    // Everything other than ILA and DATA keeps the encoder on /K/ comma characters.
    function automatic logic [2:0] mux_for_state(input link_state_e st);
        case (st)
            ST_ILA:  return LINK_MUX_ILA;
            ST_DATA: return LINK_MUX_USER;
            default: return LINK_MUX_K;
        endcase
    endfunction

endpackage

// File: rtl/tx_link_seq_sync_n_monitor.sv
// SYNC~ classifier: decides when a low SYNC~ is a re-sync request and, when
// TX_LINK_SEQ_ERR_REPORT_EN is defined, when it is only an error report.
module sync_n_monitor #(
    parameter int SYNC_REQ_FRAMES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    input  logic sync_n,
    input  logic active,
    input  logic data_phase,
    output logic request,
    output logic err_report
);

    localparam logic [3:0] REQ_LAST = 4'(SYNC_REQ_FRAMES - 1);

`ifdef TX_LINK_SEQ_ERR_REPORT_EN
    logic [3:0] sync_lo_frames;
    logic       lo_active;

    // The request fires on the frame pulse that brings the low count up to SYNC_REQ_FRAMES.
    always_comb begin
        request = active && !sync_n && frame_clk && (sync_lo_frames == REQ_LAST);
    end

    // A low episode in DATA that ends without becoming a request is an error report.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_lo_frames <= '0;
            lo_active      <= 1'b0;
            err_report     <= 1'b0;
        end else begin
            if (!active || sync_n || request) begin
                sync_lo_frames <= '0;
            end else if (frame_clk) begin
                sync_lo_frames <= sync_lo_frames + 4'd1;
            end
            lo_active  <= data_phase && !sync_n && !request;
            err_report <= data_phase && sync_n && lo_active;
        end
    end
`else
    assign request    = active && !sync_n;
    assign err_report = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, frame_clk, data_phase, REQ_LAST};
`endif

endmodule

// File: rtl/tx_link_seq.sv
// JESD204B TX link-layer sequencer: CGS, LMFC-aligned ILA, then user data.
// Optional SYNC~ error-report debouncing is enabled by TX_LINK_SEQ_ERR_REPORT_EN.
module tx_link_seq
    import jesd_tx_pkg::*;
#(
    parameter int K_MIN_FRAMES    = 4,
    parameter int ILA_MF          = 4,
    parameter int SYNC_REQ_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_clk,
    input  logic       i_lmfc_clk,
    input  logic       i_sync_n,
    input  logic       i_link_en,
    output logic [2:0] o_link_mux,
    output logic       o_ila_start,
    output logic [3:0] o_ila_mf_idx,
    output logic       o_link_up,
    output logic       o_err_report,
    output logic [7:0] o_resync_cnt
);

    localparam logic [3:0] K_MIN    = 4'(K_MIN_FRAMES);
    localparam logic [3:0] ILA_LAST = 4'(ILA_MF - 1);

    link_state_e state;
    link_state_e state_nxt;
    logic [3:0]  k_frame_cnt;
    logic [3:0]  ila_mf_cnt;
    logic        in_ila;
    logic        in_data;
    logic        sync_req;
    logic        resync_evt;

    assign in_ila  = (state == ST_ILA);
    assign in_data = (state == ST_DATA);

    sync_n_monitor #(
        .SYNC_REQ_FRAMES(SYNC_REQ_FRAMES)
    ) u_sync_mon (
        .clk        (clk),
        .rst        (rst),
        .frame_clk  (i_frame_clk),
        .sync_n     (i_sync_n),
        .active     (in_ila || in_data),
        .data_phase (in_data),
        .request    (sync_req),
        .err_report (o_err_report)
    );

    // Link disable outranks SYNC~, which outranks any LMFC-driven advance.
    always_comb begin
        state_nxt  = state;
        resync_evt = 1'b0;
        if (!i_link_en) begin
            state_nxt = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED: state_nxt = ST_CGS;
                ST_CGS: begin
                    if (i_sync_n && (k_frame_cnt >= K_MIN)) state_nxt = ST_WAIT_LMFC;
                end
                ST_WAIT_LMFC: begin
                    if (!i_sync_n)       state_nxt = ST_CGS;
                    else if (i_lmfc_clk) state_nxt = ST_ILA;
                end
                ST_ILA: begin
                    if (sync_req) begin
                        state_nxt  = ST_CGS;
                        resync_evt = 1'b1;
                    end else if (i_lmfc_clk && (ila_mf_cnt == ILA_LAST)) begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sync_req) begin
                        state_nxt  = ST_CGS;
                        resync_evt = 1'b1;
                    end
                end
                default: state_nxt = ST_DISABLED;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DISABLED;
            k_frame_cnt  <= '0;
            ila_mf_cnt   <= '0;
            o_link_mux   <= LINK_MUX_K;
            o_ila_start  <= 1'b0;
            o_link_up    <= 1'b0;
            o_resync_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt == ST_CGS && state != ST_CGS) begin
                k_frame_cnt <= '0;
            end else if (state == ST_CGS && i_frame_clk && k_frame_cnt != 4'd15) begin
                k_frame_cnt <= k_frame_cnt + 4'd1;
            end

            if (in_ila && state_nxt != ST_ILA) begin
                ila_mf_cnt <= '0;
            end else if (in_ila && i_lmfc_clk) begin
                ila_mf_cnt <= ila_mf_cnt + 4'd1;
            end

            o_link_mux  <= mux_for_state(state_nxt);
            o_ila_start <= (state_nxt == ST_ILA) && !in_ila;
            o_link_up   <= (state_nxt == ST_DATA);

            if (resync_evt && o_resync_cnt != 8'hFF) begin
                o_resync_cnt <= o_resync_cnt + 8'd1;
            end
        end
    end

    assign o_ila_mf_idx = ila_mf_cnt;

endmodule

// File: tb/tb_tx_link_seq.sv
// Directed bring-up / re-sync / abort / disable sequence for tx_link_seq with randomized
// timing; expected cycles come from arithmetic on the frame and LMFC pulse schedule.
module tb_tx_link_seq;

    localparam int K_MIN     = 4;
    localparam int ILA_MF    = 4;
    localparam int REQ       = 5;
    localparam int MF_FRAMES = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic       lmfc;
    logic       sync_n;
    logic       link_en;
    logic [2:0] mux;
    logic       ila_start;
    logic [3:0] mf_idx;
    logic       link_up;
    logic       err;
    logic [7:0] resync;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int fp         = 1;
    int lmfc_base  = 0;
    int exp_resync = 0;

    always #5 clk = ~clk;

    tx_link_seq #(
        .K_MIN_FRAMES    (K_MIN),
        .ILA_MF          (ILA_MF),
        .SYNC_REQ_FRAMES (REQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_clk  (frame),
        .i_lmfc_clk   (lmfc),
        .i_sync_n     (sync_n),
        .i_link_en    (link_en),
        .o_link_mux   (mux),
        .o_ila_start  (ila_start),
        .o_ila_mf_idx (mf_idx),
        .o_link_up    (link_up),
        .o_err_report (err),
        .o_resync_cnt (resync)
    );

    function automatic bit is_frame(input int c);
        return (c % fp) == 0;
    endfunction

    function automatic bit is_lmfc(input int c);
        return ((c - lmfc_base) % (MF_FRAMES * fp)) == 0;
    endfunction

    task automatic applyStimulus(input int n);
        repeat (n) begin
            frame = is_frame(cyc);
            lmfc  = is_lmfc(cyc);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic waitLinkUp(input string tag, input int budget);
        int n;
        n = 0;
        while (link_up !== 1'b1 && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, 32'(link_up), 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mux"}, 32'(mux), 1);
        checkOutput({tag, "_ila_start"}, 32'(ila_start), 0);
        checkOutput({tag, "_mf_idx"}, 32'(mf_idx), 0);
        checkOutput({tag, "_link_up"}, 32'(link_up), 0);
        checkOutput({tag, "_err"}, 32'(err), 0);
        checkOutput({tag, "_resync"}, 32'(resync), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c_ila, s, p, q, nfr, n, per;
        $display("[TB] tx_link_seq bench start");
        rst = 1'b1; link_en = 1'b0; sync_n = 1'b0; frame = 1'b0; lmfc = 1'b0;
        lmfc_base = $urandom_range(0, MF_FRAMES - 1);
        applyStimulus(3);
        checkResetValues("reset");

        // Bring-up with one clk per frame.
        rst = 1'b0; link_en = 1'b1;
        applyStimulus(1);
        n = $urandom_range(6, 12);
        repeat (n) begin
            applyStimulus(1);
            checkOutput("cgs_mux", 32'(mux), 1);
        end
        sync_n = 1'b1;
        c_ila = cyc + 1;
        while (!is_lmfc(c_ila)) c_ila++;
        while (cyc < c_ila) begin
            applyStimulus(1);
            checkOutput("wait_mux", 32'(mux), 1);
            checkOutput("wait_ila_start", 32'(ila_start), 0);
        end
        applyStimulus(1);
        checkOutput("ila_start", 32'(ila_start), 1);
        checkOutput("ila_first_mux", 32'(mux), 2);
        checkOutput("ila_first_idx", 32'(mf_idx), 0);
        per = MF_FRAMES * fp;
        for (int k = 1; k < ILA_MF * per; k++) begin
            applyStimulus(1);
            checkOutput("ila_mux", 32'(mux), 2);
            checkOutput("ila_idx", 32'(mf_idx), k / per);
            if (k == 1) checkOutput("ila_start_once", 32'(ila_start), 0);
        end
        applyStimulus(1);
        checkOutput("data_mux", 32'(mux), 0);
        checkOutput("data_link_up", 32'(link_up), 1);
        checkOutput("data_idx", 32'(mf_idx), 0);

        // Re-sync request from DATA, now with multi-cycle frames.
        fp = $urandom_range(2, 3);
        per = MF_FRAMES * fp;
        applyStimulus($urandom_range(1, 5));
        sync_n = 1'b0;
        p = cyc;
`ifdef TX_LINK_SEQ_ERR_REPORT_EN
        nfr = is_frame(p) ? 1 : 0;
        while (nfr < REQ) begin
            p++;
            if (is_frame(p)) nfr++;
        end
        while (cyc < p) begin
            applyStimulus(1);
            checkOutput("resync_hold_up", 32'(link_up), 1);
            checkOutput("resync_hold_cnt", 32'(resync), exp_resync);
        end
`endif
        applyStimulus(1);
        exp_resync++;
        checkOutput("resync_mux", 32'(mux), 1);
        checkOutput("resync_link_up", 32'(link_up), 0);
        checkOutput("resync_cnt", 32'(resync), exp_resync);

        // SYNC~ released after 2 CGS frames: WAIT_LMFC only once K_MIN frames are in.
        nfr = 0;
        while (nfr < 2) begin
            if (is_frame(cyc)) nfr++;
            applyStimulus(1);
            checkOutput("early_mux", 32'(mux), 1);
        end
        sync_n = 1'b1;
        q = cyc;
        while (nfr < K_MIN) begin
            if (is_frame(q)) nfr++;
            q++;
        end
        lmfc_base = q + 1;
        while (cyc <= q) begin
            applyStimulus(1);
            checkOutput("early_no_ila", 32'(ila_start), 0);
        end
        applyStimulus(1);
        checkOutput("early_ila_start", 32'(ila_start), 1);
        c_ila = q + 1;

        // Abort during multiframe 2.
        s = c_ila + 2 * per + $urandom_range(1, per - (REQ + 1) * fp);
        while (cyc < s) applyStimulus(1);
        checkOutput("abort_pre_idx", 32'(mf_idx), 2);
        sync_n = 1'b0;
        p = cyc;
`ifdef TX_LINK_SEQ_ERR_REPORT_EN
        nfr = is_frame(p) ? 1 : 0;
        while (nfr < REQ) begin
            p++;
            if (is_frame(p)) nfr++;
        end
        while (cyc < p) begin
            applyStimulus(1);
            checkOutput("abort_hold_mux", 32'(mux), 2);
        end
`endif
        applyStimulus(1);
        exp_resync++;
        checkOutput("abort_mux", 32'(mux), 1);
        checkOutput("abort_idx", 32'(mf_idx), 0);
        checkOutput("abort_resync", 32'(resync), exp_resync);

        sync_n = 1'b1;
        waitLinkUp("relink_timeout", 20 * per);

        // Short SYNC~ lows in DATA.
        applyStimulus(2);
`ifdef TX_LINK_SEQ_ERR_REPORT_EN
        n = $urandom_range(1, REQ - 1);
        sync_n = 1'b0;
        nfr = 0;
        while (nfr < n) begin
            if (is_frame(cyc)) nfr++;
            applyStimulus(1);
            checkOutput("err_quiet", 32'(err), 0);
        end
        sync_n = 1'b1;
        applyStimulus(1);
        checkOutput("err_pulse", 32'(err), 1);
        checkOutput("err_link_up", 32'(link_up), 1);
        applyStimulus(1);
        checkOutput("err_once", 32'(err), 0);
        checkOutput("err_resync", 32'(resync), exp_resync);
        while (is_frame(cyc)) applyStimulus(1);
        sync_n = 1'b0;
        applyStimulus(1);
        checkOutput("noframe_quiet", 32'(err), 0);
        sync_n = 1'b1;
        applyStimulus(1);
        checkOutput("noframe_err", 32'(err), 1);
        applyStimulus(1);
        checkOutput("noframe_once", 32'(err), 0);
        checkOutput("noframe_link_up", 32'(link_up), 1);
`else
        sync_n = 1'b0;
        applyStimulus(1);
        exp_resync++;
        checkOutput("short_low_mux", 32'(mux), 1);
        checkOutput("short_low_resync", 32'(resync), exp_resync);
        checkOutput("short_low_err", 32'(err), 0);
        sync_n = 1'b1;
        waitLinkUp("relink2_timeout", 20 * per);
`endif

        // Disable from DATA keeps the re-sync count.
        link_en = 1'b0;
        applyStimulus(1);
        checkOutput("disable_mux", 32'(mux), 1);
        checkOutput("disable_link_up", 32'(link_up), 0);
        checkOutput("disable_resync", 32'(resync), exp_resync);
        applyStimulus(2);

        // Reset in the middle of ILA.
        link_en = 1'b1;
        n = 0;
        while (ila_start !== 1'b1 && n < 10 * per) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("reach_ila_timeout", 32'(ila_start), 1);
        applyStimulus($urandom_range(1, per));
        checkOutput("pre_rst_mux", 32'(mux), 2);
        rst = 1'b1;
        applyStimulus(1);
        checkResetValues("mid_rst");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
